// File: rtl/fp_normalize_seq.sv
// Sequential normalizer for the 12-bit linear to 8-bit float converter.
// Converts a two's-complement sample to sign-magnitude and left-shifts it
// one bit per cycle until the leading one reaches bit 10 or the exponent hits 0.
module fp_normalize_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign,
    output logic [2:0]  exponent,
    output logic [3:0]  significand,
    output logic        fifth
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [11:0] mag;
    logic [2:0]  exp_cnt;
    logic [11:0] abs_in;
    logic        accept;
    logic        norm_done;

    // -2048 has no positive 12-bit counterpart, so it saturates to 0x7FF.
    always_comb begin
        if (!in_data[11])
            abs_in = in_data;
        else if (in_data == 12'h800)
            abs_in = 12'h7FF;
        else
            abs_in = 12'd0 - in_data;
    end

    assign accept    = (state == IDLE) && in_valid;
    assign norm_done = (state == NORM) && (mag[10] || (exp_cnt == 3'd0));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);

    // NOTE: state-holding registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: next state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = NORM;
            NORM:    if (norm_done) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag     <= '0;
            exp_cnt <= '0;
        end else if (accept) begin
            mag     <= abs_in;
            exp_cnt <= 3'd7;
        end else if ((state == NORM) && !norm_done) begin
            mag     <= {mag[10:0], 1'b0};
            exp_cnt <= exp_cnt - 3'd1;
        end
    end

    // Result fields are held through OUT and IDLE; consumers qualify with out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign        <= 1'b0;
            exponent    <= '0;
            significand <= '0;
            fifth       <= 1'b0;
        end else begin
            if (accept)
                sign <= in_data[11];
            if (norm_done) begin
                exponent    <= exp_cnt;
                significand <= mag[10:7];
                fifth       <= mag[6];
            end
        end
    end

endmodule

// File: tb/tb_fp_normalize_seq.sv
// Directed self-checking bench for fp_normalize_seq with hand-computed vectors.
module tb_fp_normalize_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        sign;
    logic [2:0]  exponent;
    logic [3:0]  significand;
    logic        fifth;

    int checks   = 0;
    int failures = 0;

    fp_normalize_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sign        (sign),
        .exponent    (exponent),
        .significand (significand),
        .fifth       (fifth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fields(input string tag, input logic s, input logic [2:0] e,
                                input logic [3:0] m, input logic f);
        check({tag, ".sign"},        32'(sign),        32'(s));
        check({tag, ".exponent"},    32'(exponent),    32'(e));
        check({tag, ".significand"}, 32'(significand), 32'(m));
        check({tag, ".fifth"},       32'(fifth),       32'(f));
    endtask

    // Latency counts edges starting with the accepting edge as 1.
    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) in_valid = 1'b0;
            if (out_valid) break;
        end
        if (!out_valid) check({tag, ".timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_sample(input string tag, input logic [11:0] d, input logic s,
                              input logic [2:0] e, input logic [3:0] m, input logic f,
                              input int exp_lat);
        int lat;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        wait_valid(tag, lat);
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check_fields(tag, s, e, m, f);
        @(posedge clk); #1;
        check({tag, ".consumed"}, 32'(out_valid), 32'd0);
        check({tag, ".ready_again"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        bit saw_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check_fields("reset", 1'b0, 3'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset.in_ready", 32'(in_ready), 32'd1);

        run_sample("max_pos", 12'h7FF, 1'b0, 3'd7, 4'b1111, 1'b1, 2);
        run_sample("sat_neg", 12'h800, 1'b1, 3'd7, 4'b1111, 1'b1, 2);

        // Reset mid-NORM while the fields still hold the nonzero 0x800 result.
        in_data  = 12'h000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset.out_valid", 32'(out_valid), 32'd0);
        check_fields("midreset", 1'b0, 3'd0, 4'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midreset.in_ready", 32'(in_ready), 32'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("midreset.no_valid", 32'(saw_valid), 32'd0);

        run_sample("pos_422", 12'h1A6, 1'b0, 3'd5, 4'b1101, 1'b0, 4);
        run_sample("neg_422", 12'hE5A, 1'b1, 3'd5, 4'b1101, 1'b0, 4);
        run_sample("pos_46",  12'h02E, 1'b0, 3'd2, 4'b1011, 1'b1, 7);
        run_sample("zero",    12'h000, 1'b0, 3'd0, 4'b0000, 1'b0, 9);

        // Backpressure: hold the 0x1A6 result while offering 0x7FF.
        out_ready = 1'b0;
        in_data   = 12'h1A6;
        in_valid  = 1'b1;
        wait_valid("bp", lat);
        check("bp.latency", 32'(lat), 32'd4);
        in_data  = 12'h7FF;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp.hold_valid", 32'(out_valid), 32'd1);
            check("bp.hold_ready", 32'(in_ready), 32'd0);
            check_fields("bp.hold", 1'b0, 3'd5, 4'b1101, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.release_valid", 32'(out_valid), 32'd0);
        check("bp.release_ready", 32'(in_ready), 32'd1);
        run_sample("bp.next", 12'h02E, 1'b0, 3'd2, 4'b1011, 1'b1, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_normalize_seq.md
Name: fp_normalize_seq

Overview:
- Sequential front end of the 12-bit linear to 8-bit floating-point converter. Sits directly upstream of the combinational rounding stage and feeds it {exponent, significand, fifth}; sign goes straight to the final output packer.
- Accepts one 12-bit two's-complement sample per transaction. Converts it to sign-magnitude, then normalizes it by shifting left one bit per cycle.
- Presents the 3-bit exponent, 4-bit significand, fifth (round) bit and sign to the rounding stage under a valid/ready handshake.

Parameters:
- None. Formats are fixed: 12-bit input, 3-bit exponent, 4-bit significand.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a sample (IDLE only)
- in_data  input  12  two's-complement sample
- out_valid  output  1  result fields are valid
- out_ready  input  1  downstream consumes the result
- sign  output  1  sign of the accepted sample
- exponent  output  3  normalized exponent, 0..7
- significand  output  4  normalized significand
- fifth  output  1  first bit below the significand, for the rounding stage

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of clk:
  - state goes to IDLE;
  - in_ready=1 after release;
  - out_valid=0, sign=0, exponent=0, significand=0, fifth=0;
  - internal shift register and exponent counter cleared.
- Reset asserted mid-NORM or mid-OUT discards the in-flight sample; no partial result is ever presented.
- State machine: IDLE -> NORM -> OUT -> IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1:
    - capture sign = in_data[11];
    - load mag = absolute value of in_data, 12 bits. 0x800 (-2048) saturates to 0x7FF, so mag[11] is always 0;
    - load exp counter = 7;
    - go to NORM.
- NORM, evaluated each edge:
  - If mag[10]=1 or exp=0: register the outputs and go to OUT.
    - significand = mag[10:7], fifth = mag[6], exponent = exp.
    - sign holds the captured value.
  - Otherwise: mag <= mag shifted left by 1 with zero fill, exp <= exp - 1.
  - At most 7 shifts. Result always equals exponent = max(0, 8 - leading-zero count of the 12-bit magnitude).
- OUT:
  - out_valid=1, in_ready=0.
  - All outputs hold stable until an edge with out_ready=1, then go to IDLE.
  - out_valid drops on that same edge.
- Output fields are registered; no combinational path from in_data or out_ready to any output field.
- Latency from the accepting edge to out_valid=1: s+2 cycles, where s = shift count (0..7). Range is 2..9 cycles.
- Throughput: one sample per s+3 cycles minimum, because IDLE always occupies one cycle.
- in_valid is ignored outside IDLE; the in_data of a rejected sample is never captured.
- Zero input: 7 shifts, result exponent=0, significand=0, fifth=0, sign=0.
- exponent=0 results: fifth is always 0, because zero fill shifts into mag[6].
- Field outputs keep their last values in IDLE; consumers qualify them with out_valid.

Test Plan:
1. Reset mid-NORM: apply in_data=0x000, pull rst_n low 3 cycles later, release -> all outputs 0 immediately on assertion; in_ready=1 after release; no out_valid pulse.
2. in_data=0x7FF accepted, out_ready=1 -> out_valid on the 2nd edge after accept; sign=0, exponent=7, significand=1111, fifth=1.
3. in_data=0x800 -> saturation: sign=1, exponent=7, significand=1111, fifth=1, latency 2.
4. Mid-range values:
   - in_data=0x1A6 (422) -> sign=0, exponent=5, significand=1101, fifth=0, latency 4.
   - in_data=0xE5A (-422) -> same fields with sign=1.
   - in_data=0x02E (46) -> exponent=2, significand=1011, fifth=1, latency 7.
   - in_data=0x000 -> all fields 0, latency 9.
5. Backpressure: result of 0x1A6 pending, hold out_ready=0 for 3 cycles while driving in_valid=1 with in_data=0x7FF -> outputs stable, in_ready=0, 0x7FF not captured. Raise out_ready -> return to IDLE; next accepted sample then produces its own correct result.
